// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_e         : responder FSM states (IDLE / WAIT / RESP)
//   rsp_src_e       : where the response data comes from while in RESP
//   MMIO_CYCLE_ADDR : byte address of the cycle counter, used only when
//                     DMEM_RESPONDER_MMIO_EN is defined
//   WAIT_W          : width of the wait-state counter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_ARRAY = 2'd1,
    SRC_MMIO  = 2'd2
  } rsp_src_e;

  localparam logic [31:0] MMIO_CYCLE_ADDR = 32'h8000_0000;
  localparam int          WAIT_W          = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data memory with synchronous read and byte-enabled
// synchronous write. Contents are not reset.
// Ports:
//   clk   : clock, all activity on the rising edge
//   we    : write enable for this edge
//   wstrb : byte-lane enables, bit i covers wd[8i+7:8i]
//   idx   : word index (read and write)
//   wd    : write data
//   rd    : registered read data of mem[idx] (value before any same-edge write)
module dmem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     wstrb,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wd,
  output logic [31:0]                    rd
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && wstrb[i]) begin
        mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
    rd_q <= mem[idx];
  end

  assign rd = rd_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the core's load/store port.
// Accepts one word request over valid/ready, waits WAIT_CYCLES wait states,
// then presents read data or a write acknowledgement until rsp_ready.
// Optional feature: define DMEM_RESPONDER_MMIO_EN to expose a free-running
// 32-bit cycle counter at byte address 0x8000_0000 (loads read it, stores
// are acknowledged and ignored). Without it that address is out of range.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid / req_ready : request handshake
//   req_we, req_addr      : 1 = store / 0 = load, byte address
//   req_wdata, req_wstrb  : store data and byte-lane enables
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata, rsp_err    : load data (0 for stores/errors), error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int                AW        = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] CNT_ONE   = WAIT_W'(1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  rsp_src_e          src_q, src_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_wstrb;
  logic              misaligned, out_of_range, is_mmio, cur_err;
  logic              enter_resp, arr_we;
  logic [31:0]       arr_rd;

  // With zero wait states the commit edge is the accept edge, so the live
  // request inputs must feed decode/array while in IDLE; afterwards the
  // latched copy is used so the requester may drop or change its inputs.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_wstrb = req_wstrb;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_wstrb = wstrb_q;
    end
  end

  assign misaligned   = |cur_addr[1:0];
  assign out_of_range = |cur_addr[31:AW+2];
`ifdef DMEM_RESPONDER_MMIO_EN
  assign is_mmio = (cur_addr == MMIO_CYCLE_ADDR);
`else
  assign is_mmio = 1'b0;
`endif
  assign cur_err = misaligned | (out_of_range & ~is_mmio);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    err_d      = err_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Response source and error are frozen on the edge entering RESP.
    if (enter_resp) begin
      err_d = cur_err;
      if (cur_err || cur_we) begin
        src_d = SRC_ZERO;
      end else if (is_mmio) begin
        src_d = SRC_MMIO;
      end else begin
        src_d = SRC_ARRAY;
      end
    end
  end

  // A commit coinciding with reset is dropped.
  assign arr_we = enter_resp & cur_we & ~cur_err & ~is_mmio & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= SRC_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .wstrb(cur_wstrb),
    .idx  (cur_addr[AW+1:2]),
    .wd   (cur_wdata),
    .rd   (arr_rd)
  );

`ifdef DMEM_RESPONDER_MMIO_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] snap_q, snap_d;

  always_comb begin
    cyc_d  = cyc_q + 32'd1;
    snap_d = enter_resp ? cyc_q : snap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;

  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid) begin
      case (src_q)
        SRC_ARRAY: rsp_rdata = arr_rd;
`ifdef DMEM_RESPONDER_MMIO_EN
        SRC_MMIO:  rsp_rdata = snap_q;
`endif
        default:   rsp_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances with 0, 1 and 3
// wait states, a word-array reference model, directed and random traffic.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic                  clk = 1'b0;
  logic [2:0]            rst;
  logic [2:0]            req_valid, req_we, rsp_ready;
  logic [2:0][31:0]      req_addr, req_wdata;
  logic [2:0][3:0]       req_wstrb;
  wire  [2:0]            req_ready, rsp_valid, rsp_err;
  wire  [2:0][31:0]      rsp_rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] mdl [3][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wstrb(req_wstrb[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wstrb(req_wstrb[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wstrb(req_wstrb[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  // Reference decode: aligned and below DEPTH words, or the MMIO word when built in.
  function automatic bit exp_err(input logic [31:0] a);
    bit mmio = 1'b0;
`ifdef DMEM_RESPONDER_MMIO_EN
    mmio = (a == 32'h8000_0000);
`endif
    return (a[1:0] != 2'b00) || ((a >= DEPTH * 4) && !mmio);
  endfunction

  function automatic logic [31:0] exp_load(input int d, input logic [31:0] a);
    if (exp_err(a)) return 32'h0;
    return mdl[d][a / 4];
  endfunction

  task automatic model_store(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws);
    if (!exp_err(a) && a < DEPTH * 4) begin
      for (int i = 0; i < 4; i++)
        if (ws[i]) mdl[d][a / 4][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  // One full transaction with protocol checks: accept, latency, stability
  // while rsp_ready is held low, return to IDLE after the handshake.
  task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input int hold,
                     output logic [31:0] rd, output logic er, output int t_resp);
    int lat;
    logic [31:0] r0;
    logic e0;
    @(negedge clk);
    tests++;
    if (req_ready[d] !== 1'b1) begin
      fails++; $display("FAIL idle_ready d=%0d got=%b want=1", d, req_ready[d]);
    end
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
    req_wdata[d] = wd; req_wstrb[d] = ws; rsp_ready[d] = 1'b0;
    @(posedge clk); #1;
    // Scramble request inputs: they must be ignored outside IDLE.
    req_valid[d] = 1'($urandom); req_we[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_wstrb[d] = 4'($urandom);
    lat = 0;
    @(negedge clk);
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    t_resp = cyc;
    tests++;
    if (lat !== wait_of(d)) begin
      fails++; $display("FAIL latency d=%0d addr=%h got=%0d want=%0d", d, a, lat, wait_of(d));
    end
    r0 = rsp_rdata[d]; e0 = rsp_err[d];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== r0 || rsp_err[d] !== e0 || req_ready[d] !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable d=%0d cyc=%0d got v=%b r=%h e=%b rdy=%b want v=1 r=%h e=%b rdy=0",
                 d, k, rsp_valid[d], rsp_rdata[d], rsp_err[d], req_ready[d], r0, e0);
      end
    end
    rsp_ready[d] = 1'b1; req_valid[d] = 1'b0;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    tests++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      fails++; $display("FAIL release d=%0d got v=%b rdy=%b want v=0 rdy=1", d, rsp_valid[d], req_ready[d]);
    end
    rd = r0; er = e0;
  endtask

  task automatic test_reset();
    rst = 3'b111; req_valid = '0; req_we = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 3'b000;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state d=%0d got rdy=%b v=%b r=%h e=%b want 1 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] rd, wd; logic er; int t;
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < DEPTH; w++) begin
        wd = $urandom;
        txn(d, 1'b1, w * 4, wd, 4'hF, 0, rd, er, t);
        model_store(d, w * 4, wd, 4'hF);
        tests++;
        if (er !== 1'b0 || rd !== 32'h0) begin
          fails++; $display("FAIL fill_store d=%0d w=%0d got e=%b r=%h want 0 0", d, w, er, rd);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int t;
    for (int d = 0; d < 3; d++) begin
      txn(d, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, t);
      model_store(d, 32'h10, 32'hDEADBEEF, 4'hF);
      txn(d, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, t);
      tests++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
        fails++; $display("FAIL load_deadbeef d=%0d got r=%h e=%b want deadbeef 0", d, rd, er);
      end
      txn(d, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, t);
      txn(d, 1'b1, 32'h20, 32'h000000AA, 4'b0001, 0, rd, er, t);
      txn(d, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, er, t);
      tests++;
      if (rd !== 32'h0 || er !== 1'b0) begin
        fails++; $display("FAIL nop_store_ack d=%0d got r=%h e=%b want 0 0", d, rd, er);
      end
      model_store(d, 32'h20, 32'h112233AA, 4'hF);
      txn(d, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, t);
      tests++;
      if (rd !== 32'h112233AA || er !== 1'b0) begin
        fails++; $display("FAIL byte_merge d=%0d got r=%h e=%b want 112233aa 0", d, rd, er);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int t;
    for (int d = 0; d < 3; d++) begin
      txn(d, 1'b0, 32'h22, 32'h0, 4'h0, 0, rd, er, t);
      tests++;
      if (rd !== 32'h0 || er !== 1'b1) begin
        fails++; $display("FAIL misaligned_load d=%0d got r=%h e=%b want 0 1", d, rd, er);
      end
      txn(d, 1'b0, DEPTH * 4, 32'h0, 4'h0, 0, rd, er, t);
      tests++;
      if (rd !== 32'h0 || er !== 1'b1) begin
        fails++; $display("FAIL oor_load d=%0d got r=%h e=%b want 0 1", d, rd, er);
      end
      // Errored stores must not touch the array (aliasing to word 8 or word 0).
      txn(d, 1'b1, 32'h22, 32'h55555555, 4'hF, 0, rd, er, t);
      txn(d, 1'b1, DEPTH * 4, 32'h66666666, 4'hF, 0, rd, er, t);
      tests++;
      if (er !== 1'b1) begin
        fails++; $display("FAIL oor_store_err d=%0d got e=%b want 1", d, er);
      end
      txn(d, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, t);
      tests++;
      if (rd !== exp_load(d, 32'h20) || er !== 1'b0) begin
        fails++; $display("FAIL err_no_write20 d=%0d got r=%h want %h", d, rd, exp_load(d, 32'h20));
      end
      txn(d, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, t);
      tests++;
      if (rd !== exp_load(d, 32'h0)) begin
        fails++; $display("FAIL err_no_write0 d=%0d got r=%h want %h", d, rd, exp_load(d, 32'h0));
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic er; int t;
    for (int d = 0; d < 3; d++) begin
      txn(d, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, t);
      tests++;
      if (rd !== exp_load(d, 32'h10) || er !== 1'b0) begin
        fails++; $display("FAIL hold_load d=%0d got r=%h want %h", d, rd, exp_load(d, 32'h10));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int t; bit quiet;
    for (int d = 0; d < 3; d++) begin
      txn(d, 1'b1, 32'h30, 32'h5, 4'hF, 0, rd, er, t);
      model_store(d, 32'h30, 32'h5, 4'hF);
      @(negedge clk);
      req_valid[d] = 1'b1; req_we[d] = (d != 0); req_addr[d] = 32'h30;
      req_wdata[d] = 32'hCAFE0000 | $urandom_range(255, 0); req_wstrb[d] = 4'hF;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      @(negedge clk);
      if (d == 0) begin
        tests++;
        if (rsp_valid[d] !== 1'b1) begin
          fails++; $display("FAIL w0_resp_before_reset got v=%b want 1", rsp_valid[d]);
        end
      end else begin
        for (int k = 1; k < wait_of(d); k++) @(negedge clk);
      end
      // Reset lands on the commit edge for d>0 and in RESP for d==0.
      rst[d] = 1'b1;
      @(negedge clk);
      rst[d] = 1'b0;
      tests++;
      if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || rsp_err[d] !== 1'b0 || rsp_rdata[d] !== 32'h0) begin
        fails++;
        $display("FAIL reset_mid_state d=%0d got v=%b rdy=%b e=%b r=%h want 0 1 0 0",
                 d, rsp_valid[d], req_ready[d], rsp_err[d], rsp_rdata[d]);
      end
      quiet = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (rsp_valid[d] !== 1'b0) quiet = 1'b0;
      end
      tests++;
      if (quiet !== 1'b1) begin
        fails++; $display("FAIL reset_mid_dropped d=%0d got late response want none", d);
      end
      txn(d, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, t);
      tests++;
      if (rd !== 32'h5 || er !== 1'b0) begin
        fails++; $display("FAIL reset_mid_content d=%0d got r=%h want 00000005", d, rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    bit data_ok = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h10;
    req_wdata[2] = 32'h0; req_wstrb[2] = 4'h0; rsp_ready[2] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid[2] === 1'b1) begin
        seen++;
        if (rsp_rdata[2] !== exp_load(2, 32'h10)) data_ok = 1'b0;
      end
    end
    req_valid[2] = 1'b0;
    repeat (8) @(negedge clk);
    rsp_ready[2] = 1'b0;
    tests++;
    if (seen !== 6) begin
      fails++; $display("FAIL b2b_throughput got=%0d responses want=6 in 30 cycles", seen);
    end
    tests++;
    if (data_ok !== 1'b1 || req_ready[2] !== 1'b1) begin
      fails++; $display("FAIL b2b_data got ok=%b rdy=%b want 1 1", data_ok, req_ready[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd; logic er; logic [3:0] ws; int t, kind; bit we;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 50; n++) begin
        kind = $urandom_range(9, 0);
        a = {$urandom_range(DEPTH - 1, 0), 2'b00};
        if (kind == 0) a = a | $urandom_range(3, 1);
        else if (kind == 1) a = $urandom_range(32'h7FFF_FFFF, DEPTH * 4);
        we = 1'($urandom); wd = $urandom; ws = 4'($urandom);
        txn(d, we, a, wd, ws, $urandom_range(2, 0), rd, er, t);
        tests++;
        if (er !== exp_err(a) || rd !== (we ? 32'h0 : exp_load(d, a))) begin
          fails++;
          $display("FAIL random d=%0d we=%b addr=%h got r=%h e=%b want r=%h e=%b",
                   d, we, a, rd, er, we ? 32'h0 : exp_load(d, a), exp_err(a));
        end
        if (we) model_store(d, a, wd, ws);
      end
    end
  endtask

  task automatic test_mmio();
    logic [31:0] r1, r2, rd; logic e1, e2, er; int t1, t2, t;
`ifdef DMEM_RESPONDER_MMIO_EN
    txn(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, r1, e1, t1);
    txn(1, 1'b1, 32'h8000_0000, 32'h12345678, 4'hF, 0, rd, er, t);
    tests++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      fails++; $display("FAIL mmio_store got e=%b r=%h want 0 0", er, rd);
    end
    txn(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 2, r2, e2, t2);
    tests++;
    if (e1 !== 1'b0 || e2 !== 1'b0) begin
      fails++; $display("FAIL mmio_err got e1=%b e2=%b want 0 0", e1, e2);
    end
    tests++;
    if (r2 - r1 !== 32'(t2 - t1)) begin
      fails++; $display("FAIL mmio_delta got=%0d want=%0d", r2 - r1, t2 - t1);
    end
`else
    txn(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, r1, e1, t1);
    tests++;
    if (e1 !== 1'b1 || r1 !== 32'h0) begin
      fails++; $display("FAIL mmio_absent_load got e=%b r=%h want 1 0", e1, r1);
    end
    txn(1, 1'b1, 32'h8000_0000, 32'h1, 4'hF, 0, r2, e2, t2);
    tests++;
    if (e2 !== 1'b1) begin
      fails++; $display("FAIL mmio_absent_store got e=%b want 1", e2);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_errors();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_mmio();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
